// File: rtl/ic_pkg.sv
// Shared definitions for the restore counter: the decoded per-cycle
// operation and the sizing helper for the snapshot depth field.
package ic_pkg;

   // One operation wins each cycle, in priority order restore > load > step > hold
   typedef enum logic [2:0] {
      OP_HOLD    = 3'd0,
      OP_INC     = 3'd1,
      OP_DEC     = 3'd2,
      OP_LOAD    = 3'd3,
      OP_RESTORE = 3'd4
   } op_e;

   // Bits needed to hold a snapshot count in the range 0..depth
   function automatic int stack_ptr_w(input int depth);
      return $clog2(depth + 32'sd1);
   endfunction

endpackage

// File: rtl/ic_snapshot_stack.sv
// Circular-buffer LIFO of saved count values. A push while full overwrites
// the oldest entry, which is always the slot the write pointer sits on.
module ic_snapshot_stack
   import ic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              pushData,
   output logic [WIDTH-1:0]              topData,
   output logic [stack_ptr_w(DEPTH)-1:0] depth,
   output logic                          full,
   output logic                          empty
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW    = stack_ptr_w(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [IDX_W-1:0] wr_ptr_r;
   logic [IDX_W-1:0] ptr_inc_s;
   logic [IDX_W-1:0] ptr_dec_s;
   logic [IDX_W-1:0] ptr_nxt_s;
   logic [DW-1:0]    depth_r;
   logic [DW-1:0]    depth_nxt_s;
   logic             full_r;
   logic             empty_r;

   // Neighbouring slot indices with wrap-around at DEPTH
   always_comb begin
      ptr_inc_s = IDX_W'(0);
      ptr_dec_s = IDX_W'(0);
      if (wr_ptr_r == IDX_W'(DEPTH - 1)) begin
         ptr_inc_s = IDX_W'(0);
      end else begin
         ptr_inc_s = wr_ptr_r + IDX_W'(1);
      end
      if (wr_ptr_r == IDX_W'(0)) begin
         ptr_dec_s = IDX_W'(DEPTH - 1);
      end else begin
         ptr_dec_s = wr_ptr_r - IDX_W'(1);
      end
   end

   // Next pointer and occupancy; depth saturates at DEPTH on overwrite
   always_comb begin
      ptr_nxt_s   = wr_ptr_r;
      depth_nxt_s = depth_r;
      if (push && !pop) begin
         ptr_nxt_s = ptr_inc_s;
         if (full_r) begin
            depth_nxt_s = depth_r;
         end else begin
            depth_nxt_s = depth_r + DW'(1);
         end
      end else if (pop && !push && !empty_r) begin
         ptr_nxt_s   = ptr_dec_s;
         depth_nxt_s = depth_r - DW'(1);
      end else begin
         ptr_nxt_s   = wr_ptr_r;
         depth_nxt_s = depth_r;
      end
   end

   // Pointer, occupancy and registered full/empty flags
   always_ff @(posedge clk) begin
      if (!rstN) begin
         wr_ptr_r <= IDX_W'(0);
         depth_r  <= DW'(0);
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         wr_ptr_r <= ptr_nxt_s;
         depth_r  <= depth_nxt_s;
         full_r   <= (depth_nxt_s == DW'(DEPTH));
         empty_r  <= (depth_nxt_s == DW'(0));
      end
   end

   // Entry storage; contents are meaningless while not counted in depth
   always_ff @(posedge clk) begin
      if (push && !pop) begin
         mem_r[wr_ptr_r] <= pushData;
      end
   end

   assign topData = mem_r[ptr_dec_s];
   assign depth   = depth_r;
   assign full    = full_r;
   assign empty   = empty_r;

endmodule

// File: rtl/ic_restore_counter.sv
// Registered up/down counter with runtime step, wrap or saturate arithmetic,
// direct load and a rewindable snapshot stack.
// Optional sticky wrap flag: define IC_STICKY_WRAP_EN to add clearSticky/wrapSticky.
module ic_restore_counter
   import ic_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP_W   = 2,
   parameter int DEPTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          enable,
   input  logic                          decInc,
   input  logic [STEP_W-1:0]             step,
   input  logic                          loadEn,
   input  logic [WIDTH-1:0]              loadValue,
   input  logic                          save,
   input  logic                          restore,
`ifdef IC_STICKY_WRAP_EN
   input  logic                          clearSticky,
   output logic                          wrapSticky,
`endif
   output logic [WIDTH-1:0]              count,
   output logic                          wrapped,
   output logic                          restoreErr,
   output logic [stack_ptr_w(DEPTH)-1:0] stackDepth,
   output logic                          stackFull,
   output logic                          stackEmpty
);

   op_e              op_s;
   logic             pop_s;
   logic             push_s;
   logic [WIDTH-1:0] top_data_s;
   logic [WIDTH:0]   step_ext_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] count_nxt_s;
   logic             wrap_nxt_s;
   logic             err_nxt_s;
   logic [WIDTH-1:0] count_r;
   logic             wrapped_r;
   logic             restore_err_r;

   ic_snapshot_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk      (clk),
      .rstN     (rstN),
      .push     (push_s),
      .pop      (pop_s),
      .pushData (count_r),
      .topData  (top_data_s),
      .depth    (stackDepth),
      .full     (stackFull),
      .empty    (stackEmpty)
   );

   // Decode the winning operation; a restore request always suppresses save
   always_comb begin
      pop_s     = restore & ~stackEmpty;
      push_s    = save & ~restore;
      err_nxt_s = restore & stackEmpty;
      op_s      = OP_HOLD;
      if (pop_s) begin
         op_s = OP_RESTORE;
      end else if (loadEn) begin
         op_s = OP_LOAD;
      end else if (enable) begin
         if (decInc) begin
            op_s = OP_DEC;
         end else begin
            op_s = OP_INC;
         end
      end else begin
         op_s = OP_HOLD;
      end
   end

   // Step arithmetic; the extra MSB is carry-out on add and borrow on subtract
   always_comb begin
      step_ext_s  = (WIDTH + 1)'(step);
      sum_s       = {1'b0, count_r} + step_ext_s;
      diff_s      = {1'b0, count_r} - step_ext_s;
      count_nxt_s = count_r;
      wrap_nxt_s  = 1'b0;
      case (op_s)
         OP_RESTORE: count_nxt_s = top_data_s;
         OP_LOAD:    count_nxt_s = loadValue;
         OP_INC: begin
            wrap_nxt_s = sum_s[WIDTH];
            if (sum_s[WIDTH] && (SATURATE != 0)) begin
               count_nxt_s = {WIDTH{1'b1}};
            end else begin
               count_nxt_s = sum_s[WIDTH-1:0];
            end
         end
         OP_DEC: begin
            wrap_nxt_s = diff_s[WIDTH];
            if (diff_s[WIDTH] && (SATURATE != 0)) begin
               count_nxt_s = {WIDTH{1'b0}};
            end else begin
               count_nxt_s = diff_s[WIDTH-1:0];
            end
         end
         OP_HOLD:    count_nxt_s = count_r;
         default:    count_nxt_s = count_r;
      endcase
   end

   // Count register and single-cycle event pulses
   always_ff @(posedge clk) begin
      if (!rstN) begin
         count_r       <= {WIDTH{1'b0}};
         wrapped_r     <= 1'b0;
         restore_err_r <= 1'b0;
      end else begin
         count_r       <= count_nxt_s;
         wrapped_r     <= wrap_nxt_s;
         restore_err_r <= err_nxt_s;
      end
   end

`ifdef IC_STICKY_WRAP_EN
   logic wrap_sticky_r;

   // Sticky wrap flag; a new wrap event beats a concurrent clear
   always_ff @(posedge clk) begin
      if (!rstN) begin
         wrap_sticky_r <= 1'b0;
      end else begin
         wrap_sticky_r <= wrap_nxt_s | (wrap_sticky_r & ~clearSticky);
      end
   end

   assign wrapSticky = wrap_sticky_r;
`endif

   assign count      = count_r;
   assign wrapped    = wrapped_r;
   assign restoreErr = restore_err_r;

endmodule

// File: tb/tb_ic_restore_counter.sv
// Bench for ic_restore_counter: a wrapping and a saturating instance share
// the same stimulus and are each compared with a queue-based reference model.
module tb_ic_restore_counter;

   logic       clk = 1'b0;
   logic       rstN;
   logic       enable;
   logic       decInc;
   logic [1:0] step;
   logic       loadEn;
   logic [7:0] loadValue;
   logic       save;
   logic       restore;
   logic       clearSticky;

   logic [7:0] count_w,  count_s;
   logic       wrapped_w, wrapped_s;
   logic       err_w,    err_s;
   logic [2:0] depth_w,  depth_s;
   logic       full_w,   full_s;
   logic       empty_w,  empty_s;
   logic       sticky_w, sticky_s;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state, index 0 = wrap instance, 1 = saturate instance
   int m_cnt    [2];
   int m_wr     [2];
   int m_err    [2];
   int m_sticky [2];
   int q        [2][$];

   always #5 clk = ~clk;

   ic_restore_counter #(.WIDTH(8), .STEP_W(2), .DEPTH(4), .SATURATE(0)) u_wrap (
      .clk (clk), .rstN (rstN), .enable (enable), .decInc (decInc), .step (step),
      .loadEn (loadEn), .loadValue (loadValue), .save (save), .restore (restore),
`ifdef IC_STICKY_WRAP_EN
      .clearSticky (clearSticky), .wrapSticky (sticky_w),
`endif
      .count (count_w), .wrapped (wrapped_w), .restoreErr (err_w),
      .stackDepth (depth_w), .stackFull (full_w), .stackEmpty (empty_w)
   );

   ic_restore_counter #(.WIDTH(8), .STEP_W(2), .DEPTH(4), .SATURATE(1)) u_sat (
      .clk (clk), .rstN (rstN), .enable (enable), .decInc (decInc), .step (step),
      .loadEn (loadEn), .loadValue (loadValue), .save (save), .restore (restore),
`ifdef IC_STICKY_WRAP_EN
      .clearSticky (clearSticky), .wrapSticky (sticky_s),
`endif
      .count (count_s), .wrapped (wrapped_s), .restoreErr (err_s),
      .stackDepth (depth_s), .stackFull (full_s), .stackEmpty (empty_s)
   );

`ifndef IC_STICKY_WRAP_EN
   assign sticky_w = 1'b0;
   assign sticky_s = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_wr[i] = 0; m_err[i] = 0; m_sticky[i] = 0;
         q[i].delete();
      end
   endtask

   // behavioural rules: plain integer arithmetic plus a bounded queue as the stack
   task automatic model_step(input int i);
      int r;
      m_wr[i]  = 0;
      m_err[i] = 0;
      if (restore && q[i].size() > 0) begin
         m_cnt[i] = q[i].pop_back();
      end else begin
         if (restore) m_err[i] = 1;
         if (save && !restore) begin
            if (q[i].size() == 4) void'(q[i].pop_front());
            q[i].push_back(m_cnt[i]);
         end
         if (loadEn) begin
            m_cnt[i] = int'(loadValue);
         end else if (enable) begin
            r = decInc ? m_cnt[i] - int'(step) : m_cnt[i] + int'(step);
            if (r < 0 || r > 255) begin
               m_wr[i] = 1;
               if (i == 1) r = (r < 0) ? 0 : 255;
               else        r = (r + 256) % 256;
            end
            m_cnt[i] = r;
         end
      end
      if (m_wr[i] != 0)     m_sticky[i] = 1;
      else if (clearSticky) m_sticky[i] = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/w.count"},  32'(count_w),   32'(m_cnt[0]));
      chk({tag, "/w.wrap"},   32'(wrapped_w), 32'(m_wr[0]));
      chk({tag, "/w.err"},    32'(err_w),     32'(m_err[0]));
      chk({tag, "/w.depth"},  32'(depth_w),   32'(q[0].size()));
      chk({tag, "/w.full"},   32'(full_w),    32'(q[0].size() == 4));
      chk({tag, "/w.empty"},  32'(empty_w),   32'(q[0].size() == 0));
      chk({tag, "/s.count"},  32'(count_s),   32'(m_cnt[1]));
      chk({tag, "/s.wrap"},   32'(wrapped_s), 32'(m_wr[1]));
      chk({tag, "/s.err"},    32'(err_s),     32'(m_err[1]));
      chk({tag, "/s.depth"},  32'(depth_s),   32'(q[1].size()));
      chk({tag, "/s.full"},   32'(full_s),    32'(q[1].size() == 4));
      chk({tag, "/s.empty"},  32'(empty_s),   32'(q[1].size() == 0));
`ifdef IC_STICKY_WRAP_EN
      chk({tag, "/w.sticky"}, 32'(sticky_w),  32'(m_sticky[0]));
      chk({tag, "/s.sticky"}, 32'(sticky_s),  32'(m_sticky[1]));
`endif
   endtask

   task automatic cyc(input string tag, input logic en, input logic dec, input logic [1:0] st,
                      input logic ld, input logic [7:0] lv, input logic sv, input logic rs,
                      input logic clr);
      enable = en; decInc = dec; step = st; loadEn = ld; loadValue = lv;
      save = sv; restore = rs; clearSticky = clr; rstN = 1'b1;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all(tag);
   endtask

   // reset asserted together with restore/save/enable: reset must win
   task automatic do_reset(input string tag);
      rstN = 1'b0; restore = 1'b1; save = 1'b1; enable = 1'b1; loadEn = 1'b1;
      loadValue = 8'd77; step = 2'd3; decInc = 1'b0; clearSticky = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all(tag);
      rstN = 1'b1;
   endtask

   initial begin
      rstN = 1'b0; enable = 1'b0; decInc = 1'b0; step = 2'd0; loadEn = 1'b0;
      loadValue = 8'd0; save = 1'b0; restore = 1'b0; clearSticky = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset("init");

      // reset from a busy state: count 37, two snapshots
      cyc("pre_a", 1'b0, 1'b0, 2'd0, 1'b1, 8'd5,  1'b1, 1'b0, 1'b0);
      cyc("pre_b", 1'b0, 1'b0, 2'd0, 1'b1, 8'd37, 1'b1, 1'b0, 1'b0);
      do_reset("rst_busy");

      // wrap / saturate at the top and bottom
      cyc("ld254",   1'b0, 1'b0, 2'd0, 1'b1, 8'd254, 1'b0, 1'b0, 1'b0);
      cyc("inc2",    1'b1, 1'b0, 2'd2, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
      cyc("idle",    1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
      cyc("ld1",     1'b0, 1'b0, 2'd0, 1'b1, 8'd1,   1'b0, 1'b0, 1'b0);
      cyc("dec3",    1'b1, 1'b1, 2'd3, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
      cyc("step0",   1'b1, 1'b0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);

      // LIFO restore
      cyc("ld10",    1'b0, 1'b0, 2'd0, 1'b1, 8'd10,  1'b0, 1'b0, 1'b0);
      cyc("sv_inc2", 1'b1, 1'b0, 2'd2, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0);
      cyc("sv_inc3", 1'b1, 1'b0, 2'd3, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0);
      cyc("rs1",     1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
      cyc("rs2",     1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
      cyc("rs_err",  1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0);

      // overflow: five saves into four entries
      cyc("ov_ld1",  1'b0, 1'b0, 2'd0, 1'b1, 8'd1,   1'b0, 1'b0, 1'b0);
      for (int k = 2; k <= 5; k++)
         cyc("ov_sv",   1'b0, 1'b0, 2'd0, 1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
      cyc("ov_sv5",  1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++)
         cyc("ov_rs",   1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0);

      // simultaneous events
      cyc("sim_ld20", 1'b0, 1'b0, 2'd0, 1'b1, 8'd20, 1'b0, 1'b0, 1'b0);
      cyc("sim_svin", 1'b1, 1'b0, 2'd1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0);
      cyc("sim_rs",   1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0);
      cyc("sim_sv",   1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0);
      cyc("sim_rsld", 1'b1, 1'b0, 2'd3, 1'b1, 8'd99, 1'b0, 1'b1, 1'b0);
      cyc("sim_empt", 1'b0, 1'b0, 2'd0, 1'b1, 8'd99, 1'b0, 1'b1, 1'b0);
      cyc("sim_svrs", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0);

      // sticky wrap flag
      cyc("st_ld",   1'b0, 1'b0, 2'd0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
      cyc("st_wrap", 1'b1, 1'b0, 2'd1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++)
         cyc("st_idle", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      cyc("st_ld2",  1'b0, 1'b0, 2'd0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
      cyc("st_clrw", 1'b1, 1'b0, 2'd1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1);
      cyc("st_clr",  1'b0, 1'b0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1);

      // randomized phase
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(99) < 2) begin
            do_reset("rnd_rst");
         end else begin
            cyc("rnd",
                1'($urandom_range(99) < 60), 1'($urandom_range(1)), 2'($urandom_range(3)),
                1'($urandom_range(99) < 10), 8'($urandom_range(255)),
                1'($urandom_range(99) < 30), 1'($urandom_range(99) < 25),
                1'($urandom_range(99) < 10));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ic_restore_counter.md
Name: ic_restore_counter

Overview:
- Registered, parametrised up/down counter with a multi-level snapshot/restore stack.
- Next generation of the combinational incrementer/decrementer, which only supports ±1/±2 or hold.
- Adds a runtime step of any width, wrap or saturate arithmetic, a direct load, and a DEPTH-entry LIFO of saved count values that can be restored.
- Sits between the control sequencer and any datapath that needs a rewindable counter/pointer.

Parameters:
- WIDTH, 8, count width in bits.
- STEP_W, 2, width of the step input; step range 0..2^STEP_W-1.
- DEPTH, 4, number of snapshot entries (≥1).
- SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at 0 and 2^WIDTH-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstN  in  1  synchronous active-low reset.
- enable  in  1  perform count step this cycle.
- decInc  in  1  0 = increment, 1 = decrement.
- step  in  STEP_W  step magnitude.
- loadEn  in  1  load loadValue into count.
- loadValue  in  WIDTH  value for load.
- save  in  1  push current count onto the snapshot stack.
- restore  in  1  pop top of stack into count.
- count  out  WIDTH  registered count.
- wrapped  out  1  one-cycle pulse: last update wrapped (SATURATE=0) or clamped (SATURATE=1).
- restoreErr  out  1  one-cycle pulse: restore requested with stack empty.
- stackDepth  out  $clog2(DEPTH+1)  number of valid snapshots.
- stackFull  out  1  stackDepth == DEPTH.
- stackEmpty  out  1  stackDepth == 0.

Behaviour:
- Reset (rstN=0 at a clk edge): count=0, wrapped=0, restoreErr=0, stackDepth=0, stackEmpty=1, stackFull=0. Reset overrides all inputs, including a restore or save in the same cycle. Stack contents are don't-care after reset.
- Latency: inputs are sampled at an edge; count and flags reflect them immediately after that edge (1-cycle registered). No combinational input→output paths.
- Count priority per cycle: restore (stack non-empty) > loadEn > enable > hold.
- Restore with stack non-empty:
  - count ← top entry; stackDepth decrements.
  - enable, loadEn and save are ignored that cycle.
  - wrapped=0.
- Restore with stack empty:
  - restoreErr=1 for one cycle.
  - Falls through to loadEn/enable/hold as if restore were low; save is still ignored.
- Load: count ← loadValue; wrapped=0.
- Enable, SATURATE=0: count ← (count ± step) mod 2^WIDTH. wrapped=1 on carry-out (inc) or borrow (dec).
- Enable, SATURATE=1: result clamped to 2^WIDTH-1 (inc) or 0 (dec). wrapped=1 only when clamping altered the result.
- step=0 with enable: count unchanged, wrapped=0.
- Save (no restore this cycle):
  - Pushes the pre-update count, i.e. the value before any load or enable step in the same cycle.
  - If stackFull, the oldest entry is discarded and stackDepth stays DEPTH; no error is raised.
- wrapped and restoreErr are 0 in any cycle whose condition does not occur.

Optional Feature:
- Macro: IC_STICKY_WRAP_EN.
- Defined:
  - Adds input clearSticky (1 bit) and output wrapSticky (1 bit).
  - wrapSticky sets on any cycle where wrapped would be 1 and holds until clearSticky=1 or reset.
  - If clearSticky and a wrap event occur in the same cycle, set wins.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package ic_pkg:
  - Operation enum (OP_HOLD, OP_INC, OP_DEC, OP_LOAD, OP_RESTORE) used for the decoded priority.
  - Function for the stack pointer width, $clog2(DEPTH+1).
- Sub-module ic_snapshot_stack:
  - Circular-buffer LIFO, DEPTH×WIDTH, with overwrite-oldest on push when full.
  - Ports: push, pop, pushData, topData, depth, full, empty.
- Step arithmetic and clamp stay in the top module.

Test Plan (WIDTH=8, STEP_W=2, DEPTH=4):
- Reset: run to count=37 with depth=2, hold rstN=0 for one edge with restore=1 → count=0, stackDepth=0, stackEmpty=1, all pulses 0.
- Wrap/saturate:
  - SATURATE=0: load 254, then enable inc step=2 → count=0, wrapped=1 for one cycle.
  - SATURATE=0: count=1, dec step=3 → 254, wrapped=1.
  - SATURATE=1: the same two cases give 255 and 0, each with wrapped=1.
- LIFO restore:
  - count=10 save, inc 2 → 12 save, inc 3 → 15.
  - restore → 12; restore → 10; stackEmpty=1.
  - Third restore → restoreErr=1, count stays 10.
- Overflow: save with counts 1,2,3,4,5 → stackDepth=4, stackFull=1; four restores yield 5,4,3,2; fifth restore → restoreErr=1, count=2.
- Simultaneous events:
  - count=20, save+enable inc step=1 → count=21, and a later restore returns 20.
  - restore+loadEn(99)+enable with stack non-empty → count=popped value, not 99.
  - restore+loadEn(99) with stack empty → count=99, restoreErr=1.
- Sticky (IC_STICKY_WRAP_EN): wrap once → wrapSticky=1 and stays 1 for 5 idle cycles; clearSticky concurrent with a new wrap → stays 1; clearSticky alone → 0.
